ofmap_writeback: RTL and testbench

//  Downstream of the conv/pool top. Accepts each pooled 64-bit output word with its 10-bit word

---
 rtl/ofmap_writeback_pkg.sv | 29 ++
 rtl/ofmap_writeback_if.sv | 26 ++
 rtl/ofmap_writeback_fifo.sv | 66 ++++++
 rtl/ofmap_writeback.sv | 159 +++++++++++++++
 tb/tb_ofmap_writeback.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofmap_writeback_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the ofmap write-back path.
package ofmap_writeback_pkg;

   localparam int unsigned WB_BUS_W       = 32;
   localparam int unsigned WB_DATA_W      = 2 * WB_BUS_W;
   localparam int unsigned WB_ADDR_W      = 10;
   localparam int unsigned WB_BEAT_ADDR_W = WB_ADDR_W + 1;
   localparam int unsigned WB_DEPTH       = 8;
   localparam int unsigned WB_PTR_W       = $clog2(WB_DEPTH);
   localparam int unsigned WB_CNT_W       = $clog2(WB_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   // Memory beat address: word address with the beat index as LSB.
   function automatic logic [WB_BEAT_ADDR_W-1:0] beat_addr(input logic [WB_ADDR_W-1:0] addr,
                                                           input logic beat);
      return {addr, beat};
   endfunction

endpackage

// File: rtl/ofmap_writeback_if.sv
// Pooled-word input, memory write port and status bundle of the write-back block.
interface ofmap_writeback_if;
   import ofmap_writeback_pkg::*;

   logic                      in_en;
   logic [WB_ADDR_W-1:0]      in_addr;
   logic [WB_DATA_W-1:0]      in_data;
   logic                      mem_valid;
   logic                      mem_ready;
   logic [WB_BEAT_ADDR_W-1:0] mem_addr;
   logic [WB_BUS_W-1:0]       mem_data;
   logic [WB_BEAT_ADDR_W-1:0] words_done;
   logic                      done;
   logic                      overflow;

   modport master (
      output in_en, in_addr, in_data, mem_ready,
      input  mem_valid, mem_addr, mem_data, words_done, done, overflow
   );

   modport slave (
      input  in_en, in_addr, in_data, mem_ready,
      output mem_valid, mem_addr, mem_data, words_done, done, overflow
   );

endinterface

// File: rtl/ofmap_writeback_fifo.sv
// Synchronous FIFO of {addr,data} entries; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module wb_fifo
   import ofmap_writeback_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      clear_i,
   input  logic      push_i,
   input  wb_entry_t entry_i,
   input  logic      pop_i,
   output wb_entry_t head_c_o,
   output logic      full_c_o,
   output logic      empty_c_o
);

   wb_entry_t           mem_q [WB_DEPTH];
   logic [WB_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [WB_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [WB_CNT_W-1:0] count_q, count_d;
   logic                do_push;
   logic                do_pop;

   assign full_c_o  = (count_q == WB_CNT_W'(WB_DEPTH));
   assign empty_c_o = (count_q == '0);
   assign do_pop    = pop_i && !empty_c_o;
   assign do_push   = push_i && (!full_c_o || do_pop);
   assign head_c_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + WB_PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + WB_PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + WB_CNT_W'(1);
            2'b01:   count_d = count_q - WB_CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= entry_i;
   end

endmodule

// File: rtl/ofmap_writeback.sv
// Buffers pooled 64-bit words and writes each as two 32-bit beats to memory, tracking
// completed words, layer completion and dropped pushes.
module ofmap_writeback
   import ofmap_writeback_pkg::*;
#(
   parameter int unsigned TOTAL_WORDS = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   ofmap_writeback_if.slave   bus
);

   wb_state_e                 state_q, state_d;
   logic                      mem_valid_q, mem_valid_d;
   logic [WB_BEAT_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [WB_BUS_W-1:0]       mem_data_q, mem_data_d;
   logic [WB_ADDR_W-1:0]      hold_addr_q, hold_addr_d;
   logic [WB_BUS_W-1:0]       hold_hi_q, hold_hi_d;
   logic [WB_BEAT_ADDR_W-1:0] words_done_q, words_done_d;
   logic                      done_q, done_d;
   logic                      overflow_q, overflow_d;

   wb_entry_t in_entry;
   wb_entry_t fifo_head;
   wb_entry_t next_entry;
   logic      fifo_full;
   logic      fifo_empty;
   logic      fifo_push;
   logic      fifo_pop;
   logic      bypass;
   logic      load;

   assign in_entry   = '{addr: bus.in_addr, data: bus.in_data};
   // An idle engine with nothing queued takes the input word directly for one-cycle latency.
   assign bypass     = (state_q == ST_IDLE) && fifo_empty;
   assign fifo_push  = bus.in_en && !bypass;
   assign next_entry = fifo_empty ? in_entry : fifo_head;

   wb_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .clear_i   (clear),
      .push_i    (fifo_push),
      .entry_i   (in_entry),
      .pop_i     (fifo_pop),
      .head_c_o  (fifo_head),
      .full_c_o  (fifo_full),
      .empty_c_o (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      mem_valid_d  = mem_valid_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      hold_addr_d  = hold_addr_q;
      hold_hi_d    = hold_hi_q;
      words_done_d = words_done_q;
      done_d       = done_q;
      overflow_d   = overflow_q;
      fifo_pop     = 1'b0;
      load         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty || bus.in_en) begin
               fifo_pop = !fifo_empty;
               load     = 1'b1;
            end
         end
         ST_BEAT0: begin
            if (bus.mem_ready) begin
               state_d    = ST_BEAT1;
               mem_addr_d = beat_addr(hold_addr_q, 1'b1);
               mem_data_d = hold_hi_q;
            end
         end
         ST_BEAT1: begin
            if (bus.mem_ready) begin
               if (words_done_q != '1) words_done_d = words_done_q + WB_BEAT_ADDR_W'(1);
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  load     = 1'b1;
               end else begin
                  state_d     = ST_IDLE;
                  mem_valid_d = 1'b0;
                  mem_addr_d  = '0;
                  mem_data_d  = '0;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            mem_valid_d = 1'b0;
            mem_addr_d  = '0;
            mem_data_d  = '0;
         end
      endcase

      // Start beat0 of the next word (from the FIFO head or the bypassed input).
      if (load) begin
         state_d     = ST_BEAT0;
         mem_valid_d = 1'b1;
         mem_addr_d  = beat_addr(next_entry.addr, 1'b0);
         mem_data_d  = next_entry.data[WB_BUS_W-1:0];
         hold_addr_d = next_entry.addr;
         hold_hi_d   = next_entry.data[WB_DATA_W-1:WB_BUS_W];
      end

      done_d     = done_q || (words_done_d == WB_BEAT_ADDR_W'(TOTAL_WORDS));
      overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);

      if (clear) begin
         state_d      = ST_IDLE;
         mem_valid_d  = 1'b0;
         mem_addr_d   = '0;
         mem_data_d   = '0;
         hold_addr_d  = '0;
         hold_hi_d    = '0;
         words_done_d = '0;
         done_d       = 1'b0;
         overflow_d   = 1'b0;
         fifo_pop     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         hold_addr_q  <= '0;
         hold_hi_q    <= '0;
         words_done_q <= '0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_valid_q  <= mem_valid_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         hold_addr_q  <= hold_addr_d;
         hold_hi_q    <= hold_hi_d;
         words_done_q <= words_done_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign bus.mem_valid  = mem_valid_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_data   = mem_data_q;
   assign bus.words_done = words_done_q;
   assign bus.done       = done_q;
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ofmap_writeback.sv
// Self-checking bench for ofmap_writeback: directed scenarios plus randomized traffic
// compared against a queue-based word-level model.
module tb_ofmap_writeback;

   localparam int TW    = 4;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [9:0]  a;
      logic [63:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   int   checks = 0;
   int   errors = 0;

   ofmap_writeback_if bus ();

   ofmap_writeback #(.TOTAL_WORDS(TW)) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [56:0] obs;
   assign obs = {bus.mem_valid, bus.mem_addr, bus.mem_data, bus.words_done, bus.done, bus.overflow};

   // Word-level reference: queued words, word in flight and which half is on the bus.
   ent_t m_fifo[$];
   ent_t m_cur;
   logic m_valid, m_beat, m_done, m_ovf;
   int   m_words;

   function automatic logic [56:0] expected();
      logic [10:0] a;
      logic [31:0] d;
      a = m_valid ? {m_cur.a, m_beat} : 11'd0;
      d = m_valid ? (m_beat ? m_cur.d[63:32] : m_cur.d[31:0]) : 32'd0;
      return {m_valid, a, d, 11'(m_words), m_done, m_ovf};
   endfunction

   task automatic model_reset();
      m_fifo.delete();
      m_cur   = '0;
      m_valid = 1'b0;
      m_beat  = 1'b0;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
      m_words = 0;
   endtask

   task automatic model_step(input logic en, input logic [9:0] a, input logic [63:0] d,
                             input logic rdy, input logic clr);
      int size0;
      bit popped;
      bit taken;
      ent_t e;
      if (clr) begin
         model_reset();
         return;
      end
      size0  = m_fifo.size();
      popped = 0;
      taken  = 0;
      e      = '{a: a, d: d};
      if (!m_valid) begin
         if (size0 > 0) begin
            m_cur = m_fifo.pop_front(); popped = 1; m_valid = 1'b1; m_beat = 1'b0;
         end else if (en) begin
            m_cur = e; taken = 1; m_valid = 1'b1; m_beat = 1'b0;
         end
      end else if (rdy) begin
         if (!m_beat) m_beat = 1'b1;
         else begin
            if (m_words < 2047) m_words++;
            if (m_words == TW) m_done = 1'b1;
            if (size0 > 0) begin
               m_cur = m_fifo.pop_front(); popped = 1; m_beat = 1'b0;
            end else m_valid = 1'b0;
         end
      end
      if (en && !taken) begin
         if (size0 < DEPTH || popped) m_fifo.push_back(e);
         else m_ovf = 1'b1;
      end
   endtask

   // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic cycle(input logic en, input logic [9:0] a, input logic [63:0] d,
                        input logic rdy, input logic clr);
      bus.in_en     = en;
      bus.in_addr   = a;
      bus.in_data   = d;
      bus.mem_ready = rdy;
      clear         = clr;
      model_step(en, a, d, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      clear = 1'b0;
      bus.in_en = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.mem_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs !== 57'd0) begin errors++; $display("FAIL reset: got %h want 0", obs); end
      rst = 1'b1;
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, expected()); end
   endtask

   task automatic test_single_word();
      cycle(1, 10'd5, 64'h1122334455667788, 1, 0);
      checks++;
      if ({bus.mem_valid, bus.mem_addr, bus.mem_data} !== {1'b1, 11'd10, 32'h55667788}) begin
         errors++; $display("FAIL single_beat0: got %b %0d %h", bus.mem_valid, bus.mem_addr, bus.mem_data);
      end
      cycle(0, 0, 0, 1, 0);
      checks++;
      if ({bus.mem_valid, bus.mem_addr, bus.mem_data} !== {1'b1, 11'd11, 32'h11223344}) begin
         errors++; $display("FAIL single_beat1: got %b %0d %h", bus.mem_valid, bus.mem_addr, bus.mem_data);
      end
      cycle(0, 0, 0, 1, 0);
      checks++;
      if ({bus.mem_valid, bus.words_done} !== {1'b0, 11'd1}) begin
         errors++; $display("FAIL single_done: got valid %b words %0d want 0 1", bus.mem_valid, bus.words_done);
      end
   endtask

   task automatic test_backpressure();
      cycle(1, 10'd7, 64'hAAAABBBBCCCCDDDD, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 0, 0);
         checks++;
         if ({bus.mem_valid, bus.mem_addr, bus.mem_data} !== {1'b1, 11'd14, 32'hCCCCDDDD}) begin
            errors++; $display("FAIL bp_hold %0d: got %b %0d %h", i, bus.mem_valid, bus.mem_addr, bus.mem_data);
         end
      end
      cycle(0, 0, 0, 1, 0);
      checks++;
      if ({bus.mem_valid, bus.mem_addr, bus.mem_data} !== {1'b1, 11'd15, 32'hAAAABBBB}) begin
         errors++; $display("FAIL bp_beat1: got %b %0d %h", bus.mem_valid, bus.mem_addr, bus.mem_data);
      end
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (obs !== expected() || bus.words_done !== 11'd2) begin
         errors++; $display("FAIL bp_end: got %h want %h", obs, expected());
      end
   endtask

   task automatic test_burst_overflow();
      int vcount = 0;
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         cycle(1, 10'(i + 100), rnd64(), 1, 0);
         if (bus.mem_valid === 1'b1) vcount++;
         checks++;
         if (obs !== expected()) begin errors++; $display("FAIL burst_push %0d: got %h want %h", i, obs, expected()); end
      end
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, 0, 1, 0);
         if (bus.mem_valid === 1'b1) vcount++;
         checks++;
         if (obs !== expected()) begin errors++; $display("FAIL burst_drain %0d: got %h want %h", i, obs, expected()); end
      end
      checks++;
      if (vcount != 16 || bus.words_done !== 11'd8 || bus.overflow !== 1'b0) begin
         errors++; $display("FAIL burst_total: beats %0d words %0d ovf %b want 16 8 0", vcount, bus.words_done, bus.overflow);
      end
      for (int i = 0; i < 10; i++) begin
         cycle(1, 10'(i + 200), rnd64(), 0, 0);
         if (i == 8) begin
            checks++;
            if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
         end
      end
      checks++;
      if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 0, 1, 0);
         checks++;
         if (obs !== expected()) begin errors++; $display("FAIL ovf_drain %0d: got %h want %h", i, obs, expected()); end
      end
      checks++;
      if (bus.words_done !== 11'd17) begin errors++; $display("FAIL ovf_words: got %0d want 17", bus.words_done); end
   endtask

   task automatic test_completion();
      cycle(0, 0, 0, 0, 1);
      checks++;
      if ({bus.words_done, bus.done} !== {11'd0, 1'b0}) begin
         errors++; $display("FAIL comp_clear0: got %0d %b want 0 0", bus.words_done, bus.done);
      end
      for (int c = 1; c <= 12; c++) begin
         cycle(c <= 4, 10'(c + 40), rnd64(), 1, 0);
         checks++;
         if (obs !== expected()) begin errors++; $display("FAIL comp_cyc %0d: got %h want %h", c, obs, expected()); end
         if (c == 8 || c == 9) begin
            checks++;
            if ({bus.words_done, bus.done} !== ((c == 8) ? {11'd3, 1'b0} : {11'd4, 1'b1})) begin
               errors++; $display("FAIL comp_edge %0d: got %0d %b", c, bus.words_done, bus.done);
            end
         end
      end
      cycle(0, 0, 0, 1, 1);
      checks++;
      if ({bus.done, bus.words_done, bus.overflow, bus.mem_valid} !== 14'd0) begin
         errors++; $display("FAIL comp_clear: got done %b words %0d", bus.done, bus.words_done);
      end
   endtask

   task automatic test_full_pop();
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) cycle(1, 10'(i + 300), rnd64(), 0, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(1, 10'd400, 64'hDEADBEEFCAFEF00D, 1, 0);
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", bus.overflow); end
      for (int i = 0; i < 24; i++) begin
         cycle(0, 0, 0, 1, 0);
         checks++;
         if (obs !== expected()) begin errors++; $display("FAIL fullpop_drain %0d: got %h want %h", i, obs, expected()); end
      end
      checks++;
      if ({bus.words_done, bus.overflow} !== {11'd10, 1'b0}) begin
         errors++; $display("FAIL fullpop_words: got %0d %b want 10 0", bus.words_done, bus.overflow);
      end
   endtask

   task automatic test_random();
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 600; i++) begin
         int en_pct = (i < 300) ? 30 : 60;
         cycle($urandom_range(0, 99) < en_pct, 10'($urandom), rnd64(),
               $urandom_range(0, 99) < 70, $urandom_range(0, 199) == 0);
         checks++;
         if (obs !== expected()) begin errors++; $display("FAIL random %0d: got %h want %h", i, obs, expected()); end
      end
   endtask

   task automatic test_async_reset();
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(1, 10'(i + 500), rnd64(), 0, 0);
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (obs !== expected() || bus.mem_addr[0] !== 1'b1) begin
         errors++; $display("FAIL arst_setup: got %h want %h", obs, expected());
      end
      bus.mem_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs !== 57'd0) begin errors++; $display("FAIL arst_async: got %h want 0", obs); end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 1, 0);
         checks++;
         if (bus.mem_valid !== 1'b0 || obs !== expected()) begin
            errors++; $display("FAIL arst_idle %0d: got %h want %h", i, obs, expected());
         end
      end
      cycle(1, 10'd9, 64'h0123456789ABCDEF, 1, 0);
      checks++;
      if ({bus.mem_valid, bus.mem_addr, bus.mem_data} !== {1'b1, 11'd18, 32'h89ABCDEF}) begin
         errors++; $display("FAIL arst_new: got %b %0d %h", bus.mem_valid, bus.mem_addr, bus.mem_data);
      end
      repeat (3) cycle(0, 0, 0, 1, 0);
      checks++;
      if (bus.words_done !== 11'd1) begin errors++; $display("FAIL arst_words: got %0d want 1", bus.words_done); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_backpressure();
      test_burst_overflow();
      test_completion();
      test_full_pop();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
